vga_timing_gen: RTL and testbench

- Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock.
- Drives `DrawX`, `DrawY` and `blank` into the sprite/scene renderers.
- Produces sync outputs delayed to line up with the renderers' registered RGB.
- Also provides frame/line strobes and a frame counter for animation logic.

---
 rtl/vga_timing_pkg.sv | 37 +++
 rtl/sync_delay_line.sv | 34 +++
 rtl/vga_timing_gen.sv | 118 +++++++++++
 tb/tb_vga_timing_gen.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 constants for the VGA raster timing slice.
package vga_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    localparam int unsigned DEF_H_TOTAL = h_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int unsigned DEF_V_TOTAL = v_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } sync_t;

    // Idle level: syncs deasserted (high), nothing visible.
    localparam sync_t SYNC_RESET = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register for the sync/blank bundle; depth 0 is a pass-through.
module sync_delay_line
    import vga_timing_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic  vga_clk,
    input  logic  reset,
    input  sync_t din,
    output sync_t dout
);

    if (DEPTH == 0) begin : g_pass
        assign dout = din;
    end else begin : g_pipe
        sync_t stage [DEPTH];

        always_ff @(posedge vga_clk) begin
            if (reset) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage[i] <= SYNC_RESET;
                end
            end else begin
                stage[0] <= din;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign dout = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, sync/blank decode, line/frame strobes and frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE         = DEF_H_ACTIVE,
    parameter int unsigned H_FP             = DEF_H_FP,
    parameter int unsigned H_SYNC           = DEF_H_SYNC,
    parameter int unsigned H_BP             = DEF_H_BP,
    parameter int unsigned V_ACTIVE         = DEF_V_ACTIVE,
    parameter int unsigned V_FP             = DEF_V_FP,
    parameter int unsigned V_SYNC           = DEF_V_SYNC,
    parameter int unsigned V_BP             = DEF_V_BP,
    parameter int unsigned SYNC_DELAY       = 1,
    parameter logic [15:0] FRAME_COUNT_INIT = '0
) (
    input  logic        vga_clk,
    input  logic        reset,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        hs_d,
    output logic        vs_d,
    output logic        blank_d,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > 1024) begin : g_h_total_check
        $fatal(1, "vga_timing_gen: H_TOTAL exceeds the 10-bit counter");
    end
    if (V_TOTAL > 1024) begin : g_v_total_check
        $fatal(1, "vga_timing_gen: V_TOTAL exceeds the 10-bit counter");
    end
    if (SYNC_DELAY > 4) begin : g_delay_check
        $fatal(1, "vga_timing_gen: SYNC_DELAY must be 0..4");
    end

    localparam coord_t H_LAST       = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST       = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS        = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS        = coord_t'(V_ACTIVE);
    localparam coord_t H_SYNC_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t H_SYNC_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t V_SYNC_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t V_SYNC_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    coord_t      h_q;
    coord_t      v_q;
    logic        line_start_q;
    logic        frame_start_q;
    logic [15:0] frame_count_q;
    logic        h_wrap;
    logic        v_wrap;

    assign h_wrap = (h_q == H_LAST);
    assign v_wrap = (v_q == V_LAST);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            h_q           <= '0;
            v_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= FRAME_COUNT_INIT;
        end else begin
            // Strobes are registered so they coincide with the (0,0) / h=0 cycle itself.
            line_start_q  <= h_wrap;
            frame_start_q <= h_wrap && v_wrap;
            if (h_wrap) begin
                h_q <= '0;
                v_q <= v_wrap ? '0 : v_q + 10'd1;
            end else begin
                h_q <= h_q + 10'd1;
            end
            if (h_wrap && v_wrap) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

    sync_t sync_now;
    sync_t sync_del;

    always_comb begin
        sync_now       = SYNC_RESET;
        sync_now.blank = (h_q < H_VIS) && (v_q < V_VIS);
        sync_now.hs    = !((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
        sync_now.vs    = !((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));
    end

    sync_delay_line #(
        .DEPTH (SYNC_DELAY)
    ) u_sync_delay (
        .vga_clk (vga_clk),
        .reset   (reset),
        .din     (sync_now),
        .dout    (sync_del)
    );

    assign DrawX       = h_q;
    assign DrawY       = v_q;
    assign blank       = sync_now.blank;
    assign hs          = sync_now.hs;
    assign vs          = sync_now.vs;
    assign hs_d        = sync_del.hs;
    assign vs_d        = sync_del.vs;
    assign blank_d     = sync_del.blank;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench: default-timing builds at three delays, plus small-raster builds.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    // u_d1: default timing, SYNC_DELAY=1
    logic [9:0]  x1, y1;
    logic        bl1, hs1, vs1, hsd1, vsd1, bld1, ls1, fs1;
    logic [15:0] fc1;
    // u_d0: SYNC_DELAY=0
    logic [9:0]  x0, y0;
    logic        bl0, hs0, vs0, hsd0, vsd0, bld0, ls0, fs0;
    logic [15:0] fc0;
    // u_d3: SYNC_DELAY=3
    logic [9:0]  x3, y3;
    logic        bl3, hs3, vs3, hsd3, vsd3, bld3, ls3, fs3;
    logic [15:0] fc3;
    // u_sa: small raster 12x7
    logic [9:0]  xa, ya;
    logic        bla, hsa, vsa, hsda, vsda, blda, lsa, fsa;
    logic [15:0] fca;
    // u_sb: small raster, frame counter starting near wrap
    logic [9:0]  xb, yb;
    logic        blb, hsb, vsb, hsdb, vsdb, bldb, lsb, fsb;
    logic [15:0] fcb;

    vga_timing_gen #(.SYNC_DELAY(1)) u_d1 (
        .vga_clk(clk), .reset(rst), .DrawX(x1), .DrawY(y1), .blank(bl1), .hs(hs1), .vs(vs1),
        .hs_d(hsd1), .vs_d(vsd1), .blank_d(bld1), .line_start(ls1), .frame_start(fs1),
        .frame_count(fc1));

    vga_timing_gen #(.SYNC_DELAY(0)) u_d0 (
        .vga_clk(clk), .reset(rst), .DrawX(x0), .DrawY(y0), .blank(bl0), .hs(hs0), .vs(vs0),
        .hs_d(hsd0), .vs_d(vsd0), .blank_d(bld0), .line_start(ls0), .frame_start(fs0),
        .frame_count(fc0));

    vga_timing_gen #(.SYNC_DELAY(3)) u_d3 (
        .vga_clk(clk), .reset(rst), .DrawX(x3), .DrawY(y3), .blank(bl3), .hs(hs3), .vs(vs3),
        .hs_d(hsd3), .vs_d(vsd3), .blank_d(bld3), .line_start(ls3), .frame_start(fs3),
        .frame_count(fc3));

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_DELAY(1)) u_sa (
        .vga_clk(clk), .reset(rst_a), .DrawX(xa), .DrawY(ya), .blank(bla), .hs(hsa), .vs(vsa),
        .hs_d(hsda), .vs_d(vsda), .blank_d(blda), .line_start(lsa), .frame_start(fsa),
        .frame_count(fca));

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_DELAY(1),
                     .FRAME_COUNT_INIT(16'hFFFE)) u_sb (
        .vga_clk(clk), .reset(rst_b), .DrawX(xb), .DrawY(yb), .blank(blb), .hs(hsb), .vs(vsb),
        .hs_d(hsdb), .vs_d(vsdb), .blank_d(bldb), .line_start(lsb), .frame_start(fsb),
        .frame_count(fcb));

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bl_err, x_err, hs_low, ls_cnt, fs_cnt, vs_low, n;
        int first_hs, first_hsd0, first_hsd1, first_hsd3, first_bld1;

        rst = 1'b1; rst_a = 1'b1; rst_b = 1'b1;
        repeat (10) tick();

        // Reset hold
        check("rst_DrawX", x1, 0);
        check("rst_DrawY", y1, 0);
        check("rst_hs", hs1, 1);
        check("rst_vs", vs1, 1);
        check("rst_hs_d", hsd1, 1);
        check("rst_vs_d", vsd1, 1);
        check("rst_blank", bl1, 1);
        check("rst_blank_d", bld1, 0);
        check("rst_frame_count", fc1, 0);
        check("rst_line_start", ls1, 0);
        check("rst_frame_start", fs1, 0);
        check("rst_hs_d3", hsd3, 1);

        // One full line from reset release on the default-timing builds
        rst = 1'b0; rst_a = 1'b0;
        bl_err = 0; x_err = 0; hs_low = 0; ls_cnt = 0; fs_cnt = 0;
        first_hs = -1; first_hsd0 = -1; first_hsd1 = -1; first_hsd3 = -1; first_bld1 = -1;
        for (int i = 0; i < 800; i++) begin
            if (x1 !== 10'(i) || y1 !== 10'd0) x_err++;
            if (bl1 !== (i < 640)) bl_err++;
            if (hs1 === 1'b0) begin
                hs_low++;
                if (i < 656 || i > 751) x_err++;
            end
            if (ls1 === 1'b1) ls_cnt++;
            if (fs1 === 1'b1) fs_cnt++;
            if (hs1 === 1'b0 && first_hs < 0) first_hs = i;
            if (hsd0 === 1'b0 && first_hsd0 < 0) first_hsd0 = i;
            if (hsd1 === 1'b0 && first_hsd1 < 0) first_hsd1 = i;
            if (hsd3 === 1'b0 && first_hsd3 < 0) first_hsd3 = i;
            if (i > 0 && bld1 === 1'b0 && first_bld1 < 0) first_bld1 = i;
            tick();
        end
        check("line_counter_seq", x_err, 0);
        check("line_blank_decode", bl_err, 0);
        check("line_hs_low_clocks", hs_low, 96);
        check("line_hs_fall_x", first_hs, 656);
        check("line_no_strobe_in_line", ls_cnt + fs_cnt, 0);
        check("delay0_hs_d_fall", first_hsd0, 656);
        check("delay1_hs_d_fall", first_hsd1, 657);
        check("delay3_hs_d_fall", first_hsd3, 659);
        check("delay1_blank_d_fall", first_bld1, 641);
        check("wrap_DrawX", x1, 0);
        check("wrap_DrawY", y1, 1);
        check("wrap_line_start", ls1, 1);
        check("wrap_frame_start", fs1, 0);
        tick();
        check("line_start_single", ls1, 0);
        check("line_x_after_wrap", x1, 1);

        // Mid-frame reset of the small raster at (5,3)
        n = 0;
        while (!(xa === 10'd5 && ya === 10'd3) && n < 200) begin
            tick();
            n++;
        end
        check("sa_reach_5_3", n < 200, 1);
        check("sa_frames_before_reset", fca != 16'd0, 1);
        rst_a = 1'b1;
        tick();
        check("mid_rst_DrawX", xa, 0);
        check("mid_rst_DrawY", ya, 0);
        check("mid_rst_frame_count", fca, 0);
        check("mid_rst_frame_start", fsa, 0);
        rst_a = 1'b0;

        // Full small frame (12 x 7 = 84 clocks) after the release
        x_err = 0; vs_low = 0; ls_cnt = 0; fs_cnt = 0;
        for (int i = 0; i < 84; i++) begin
            if (xa !== 10'(i % 12) || ya !== 10'(i / 12)) x_err++;
            if (vsa === 1'b0) begin
                vs_low++;
                if (ya !== 10'd5) x_err++;
            end
            if (lsa === 1'b1) ls_cnt++;
            if (fsa === 1'b1) fs_cnt++;
            tick();
        end
        check("sa_counter_seq", x_err, 0);
        check("sa_vs_low_clocks", vs_low, 12);
        check("sa_line_starts", ls_cnt, 6);
        check("sa_no_early_frame_start", fs_cnt, 0);
        check("sa_wrap_DrawX", xa, 0);
        check("sa_wrap_DrawY", ya, 0);
        check("sa_wrap_frame_start", fsa, 1);
        check("sa_wrap_line_start", lsa, 1);
        check("sa_wrap_frame_count", fca, 1);
        tick();
        check("sa_frame_start_single", fsa, 0);
        check("sa_line_start_single", lsa, 0);
        check("sa_frame_count_hold", fca, 1);

        // Frame counter wrap 65535 -> 0
        rst_b = 1'b0;
        check("sb_init_count", fcb, 16'hFFFE);
        repeat (84) tick();
        check("sb_fs_first", fsb, 1);
        check("sb_count_65535", fcb, 16'hFFFF);
        repeat (84) tick();
        check("sb_fs_second", fsb, 1);
        check("sb_count_wrapped", fcb, 0);
        check("sb_wrap_xy", {xb, yb}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
